// File: rtl/magnitude_compare_seq.sv
// Multi-cycle MSB-first magnitude comparator with start/busy/done handshake.
// Optional build macro COMPARE_EARLY_EXIT_EN ends the scan once a slice differs.
module magnitude_compare_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_cmp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             decided, gt_r, lt_r;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [WIDTH-1:0] sign_flip;
  logic             finish;

  assign a_dig = a_sh[WIDTH-1 -: DIGIT];
  assign b_dig = b_sh[WIDTH-1 -: DIGIT];

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_flip = {signed_cmp, {(WIDTH-1){1'b0}}};

  // The last slice is evaluated on one edge and reported on the next, so
  // RUN spends one extra cycle after the scan before entering DONE.
`ifdef COMPARE_EARLY_EXIT_EN
  assign finish = (cnt == CW'(N)) || decided;
`else
  assign finish = (cnt == CW'(N));
`endif

  // NOTE: every register here is updated with <= so all state advances
  // together on the edge; blocking writes would make later reads see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      // NOTE: done defaults low each cycle so it can only ever be a single pulse.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh    <= a ^ sign_flip;
            b_sh    <= b ^ sign_flip;
            cnt     <= '0;
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= gt_r;
            lt    <= lt_r;
            eq    <= ~decided;
          end else begin
            if (!decided && (a_dig != b_dig)) begin
              decided <= 1'b1;
              gt_r    <= (a_dig > b_dig);
              lt_r    <= (a_dig < b_dig);
            end
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
            cnt  <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_compare_seq.sv
// Scoreboard bench for magnitude_compare_seq: results and latency are predicted
// at issue time and compared when done pulses.
module tb_magnitude_compare_seq;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             signed_cmp = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, gt, lt, eq;

  magnitude_compare_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_cmp(signed_cmp),
    .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] gle;
    int         lat;
    int         issue;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic sgn, input int issue);
    exp_t e;
    logic signed [WIDTH-1:0] sa, sb_v;
    logic is_gt, is_lt;
    sa   = ma;
    sb_v = mb;
    is_gt = sgn ? (sa > sb_v) : (ma > mb);
    is_lt = sgn ? (sa < sb_v) : (ma < mb);
    e.gle   = {is_gt, is_lt, !(is_gt || is_lt)};
    e.lat   = N + 1;
    e.issue = issue;
`ifdef COMPARE_EARLY_EXIT_EN
    for (int k = N; k >= 1; k--) begin
      if (((ma ^ mb) >> (WIDTH - DIGIT * k)) % (1 << DIGIT) != 0) e.lat = k + 1;
    end
`endif
    return e;
  endfunction

  // Result checker: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_gle", {29'b0, gt, lt, eq}, {29'b0, e.gle});
        check("latency", cyc - e.issue - 1, e.lat);
        check("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic sgn);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; signed_cmp = sgn;
    sb.push_back(model(ia, ib, sgn, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic rs;

    repeat (2) @(negedge clk);
    check("reset_outs", {27'b0, busy, done, gt, lt, eq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {27'b0, busy, done, gt, lt, eq}, 32'd0);

    issue(16'h1234, 16'h1234, 1'b0); wait_idle();
    issue(16'h8000, 16'h7FFF, 1'b0); wait_idle();
    issue(16'h8000, 16'h7FFF, 1'b1); wait_idle();
    issue(16'hF000, 16'h0000, 1'b0); wait_idle();
    issue(16'h0001, 16'h0000, 1'b0); wait_idle();
    issue(16'h0123, 16'h0124, 1'b1); wait_idle();

    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 3 == 0) ? ra : WIDTH'($urandom);
      rs = 1'($urandom);
      issue(ra, rb, rs);
      wait_idle();
    end

    // Start and operand changes while busy must not disturb the running compare.
    issue(16'h0010, 16'h0020, 1'b0);
    start = 1'b1; a = 16'hFFFF; b = 16'h0000; signed_cmp = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0000; b = 16'hFFFF;
    check("busy_mid_run", {31'b0, busy}, 32'd1);
    wait_idle();

    // Reset in the middle of a run abandons it without a done pulse.
    issue(16'h0001, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_run", {27'b0, busy, done, gt, lt, eq}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_quiet", {27'b0, busy, done, gt, lt, eq}, 32'd0);
    issue(16'h0002, 16'h0003, 1'b0); wait_idle();
    check("post_rst_lt", {29'b0, gt, lt, eq}, 32'b010);

    // Back-to-back: new start on the done cycle, previous result held meanwhile.
    issue(16'h0300, 16'h0200, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("b2b_done_seen", {31'b0, done}, 32'd1);
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; signed_cmp = 1'b1;
    sb.push_back(model(16'hFFFF, 16'h0001, 1'b1, cyc));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_held", {29'b0, gt, lt, eq}, 32'b100);
    wait_idle();
    check("b2b_final", {29'b0, gt, lt, eq}, 32'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
